l3_cmd_dispatch: RTL

- Initiator side of the L3 command interface. Parses L3 request frames from the SPI RX byte stream and issues cmd_en/cmd_op/wr_size/cmd_extend to the ECC core control unit.
- Forwards write payload while the core holds the write window open, collects resp_done/resp_veri/resp_err, and serialises a status byte plus any read-back data onto the SPI TX byte stream.
- Sits between the SPI byte framer and the ECC core control unit.

---
 rtl/l3_pkg.sv | 25 ++
 rtl/l3_timeout_cnt.sv | 34 +++
 rtl/l3_cmd_dispatch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/l3_pkg.sv
// Shared encodings and constants for the L3 command dispatcher.
// Status byte layout and the timeout marker are common to the dispatcher and its users.
package l3_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_HDR       = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_CORE = 3'd3;
   localparam logic [2:0] ST_WR_DATA   = 3'd4;
   localparam logic [2:0] ST_TX_STAT   = 3'd5;
   localparam logic [2:0] ST_TX_DATA   = 3'd6;

   localparam int HDR_LEN = 5;

   localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;

   localparam logic [1:0] ERR_CMD  = 2'b01;
   localparam logic [1:0] ERR_SIZE = 2'b10;
   localparam logic [1:0] ERR_PRM  = 2'b11;

   function automatic logic [7:0] status_byte(input logic veri, input logic [1:0] err);
      return {5'b0, veri, err};
   endfunction

endpackage

// File: rtl/l3_timeout_cnt.sv
// Command watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the budget of TO_CYCLES is used up.
module l3_timeout_cnt #(
   parameter int TO_CYCLES = 1048576,
   parameter int TO_W      = 21
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + TO_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Fires on the last counted cycle so the state change lands exactly TO_CYCLES after clear.
   assign expire_o = en_i && (cnt_q == TO_W'(TO_CYCLES - 1));

endmodule

// File: rtl/l3_cmd_dispatch.sv
// L3 command initiator: parses request frames from the SPI RX stream, drives the
// ECC core command/write/read handshakes and returns status plus read-back on SPI TX.
module l3_cmd_dispatch
   import l3_pkg::*;
#(
   parameter int TO_CYCLES = 1048576,
   parameter int TO_W      = 21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        rx_frame,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        cmd_rdy,
   output logic        cmd_en,
   output logic [7:0]  cmd_op,
   output logic [15:0] wr_size,
   output logic [15:0] cmd_extend,
   input  logic        wr_open,
   output logic        wr_valid,
   output logic [7:0]  wr_data,
   output logic        rcv_done,
   input  logic        rd_open,
   output logic        rd_req,
   input  logic [7:0]  rd_data,
   input  logic        resp_done,
   input  logic        resp_veri,
   input  logic [1:0]  resp_err,
   output logic        busy
);

   logic [2:0]  state_q, state_d;
   logic [7:0]  cmd_op_q, cmd_op_d;
   logic [15:0] wr_size_q, wr_size_d;
   logic [15:0] ext_q, ext_d;
   logic [2:0]  hdr_cnt_q, hdr_cnt_d;
   logic        rd_flag_q, rd_flag_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        rd_pend_q, rd_pend_d;
   logic        cmd_en_q, cmd_en_d;
   logic        rcv_done_q, rcv_done_d;
   logic        rd_req_q, rd_req_d;
   logic        to_clr, to_en, to_exp;
   logic        rx_acc, enter_stat;
   logic [7:0]  stat_val;

   l3_timeout_cnt #(.TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) u_to (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (to_clr),
      .en_i     (to_en),
      .expire_o (to_exp)
   );

   assign rx_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_HDR) | (state_q == ST_WR_DATA));
   assign rx_acc   = rx_valid & rx_ready;
   assign wr_valid = (state_q == ST_WR_DATA) & rx_acc;
   assign wr_data  = wr_valid ? rx_data : 8'h00;
   // A read byte is offered straight from the core the cycle it arrives, then held locally.
   assign tx_valid = tx_valid_q | rd_pend_q;
   assign tx_data  = rd_pend_q ? rd_data : tx_data_q;
   assign cmd_en     = cmd_en_q;
   assign rcv_done   = rcv_done_q;
   assign rd_req     = rd_req_q;
   assign cmd_op     = cmd_op_q;
   assign wr_size    = wr_size_q;
   assign cmd_extend = ext_q;
   assign busy       = (state_q != ST_IDLE);

   always_comb begin
      state_d    = state_q;
      cmd_op_d   = cmd_op_q;
      wr_size_d  = wr_size_q;
      ext_d      = ext_q;
      hdr_cnt_d  = hdr_cnt_q;
      rd_flag_d  = rd_flag_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      rd_pend_d  = rd_req_q;
      cmd_en_d   = 1'b0;
      rcv_done_d = 1'b0;
      rd_req_d   = 1'b0;
      to_clr     = 1'b0;
      to_en      = 1'b0;
      enter_stat = 1'b0;
      stat_val   = STATUS_TIMEOUT;

      case (state_q)
         ST_IDLE: begin
            if (rx_acc && rx_frame) begin
               cmd_op_d  = rx_data;
               hdr_cnt_d = 3'd0;
               state_d   = ST_HDR;
            end
         end
         ST_HDR: begin
            if (!rx_frame) begin
               state_d = ST_IDLE;
            end else if (rx_acc) begin
               case (hdr_cnt_q[1:0])
                  2'd0:    wr_size_d[15:8] = rx_data;
                  2'd1:    wr_size_d[7:0]  = rx_data;
                  2'd2:    ext_d[15:8]     = rx_data;
                  default: ext_d[7:0]      = rx_data;
               endcase
               hdr_cnt_d = hdr_cnt_q + 3'd1;
               if (hdr_cnt_q == 3'(HDR_LEN - 2))
                  state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_rdy) begin
               cmd_en_d  = 1'b1;
               to_clr    = 1'b1;
               rd_flag_d = 1'b0;
               state_d   = ST_WAIT_CORE;
            end
         end
         ST_WAIT_CORE, ST_WR_DATA: begin
            to_en = 1'b1;
            if (rd_open)
               rd_flag_d = 1'b1;
            if (resp_done) begin
               enter_stat = 1'b1;
               stat_val   = status_byte(resp_veri, resp_err);
            end else if (to_exp) begin
               enter_stat = 1'b1;
            end else if (state_q == ST_WAIT_CORE) begin
               if (wr_open) begin
                  cnt_d = 16'd0;
                  if (wr_size_q == 16'd0)
                     rcv_done_d = 1'b1;
                  else
                     state_d = ST_WR_DATA;
               end
            end else if (rx_acc) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q + 16'd1 == wr_size_q) begin
                  rcv_done_d = 1'b1;
                  state_d    = ST_WAIT_CORE;
               end
            end
         end
         ST_TX_STAT: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               cnt_d      = 16'd0;
               state_d    = (rd_flag_q && tx_data_q != STATUS_TIMEOUT) ? ST_TX_DATA : ST_IDLE;
            end
         end
         ST_TX_DATA: begin
            // One read outstanding at a time: request, capture, hand off, then request again.
            if (rd_pend_q) begin
               if (!tx_ready) begin
                  tx_valid_d = 1'b1;
                  tx_data_d  = rd_data;
               end
            end else if (tx_valid_q) begin
               if (tx_ready)
                  tx_valid_d = 1'b0;
            end else if (!rd_req_q) begin
               if (cnt_q == ext_q) begin
                  state_d = ST_IDLE;
               end else begin
                  rd_req_d = 1'b1;
                  cnt_d    = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (enter_stat) begin
         state_d    = ST_TX_STAT;
         tx_valid_d = 1'b1;
         tx_data_d  = stat_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cmd_op_q   <= 8'h00;
         wr_size_q  <= 16'h0000;
         ext_q      <= 16'h0000;
         hdr_cnt_q  <= 3'd0;
         rd_flag_q  <= 1'b0;
         cnt_q      <= 16'h0000;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         cmd_en_q   <= 1'b0;
         rcv_done_q <= 1'b0;
         rd_req_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_op_q   <= cmd_op_d;
         wr_size_q  <= wr_size_d;
         ext_q      <= ext_d;
         hdr_cnt_q  <= hdr_cnt_d;
         rd_flag_q  <= rd_flag_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         rd_pend_q  <= rd_pend_d;
         cmd_en_q   <= cmd_en_d;
         rcv_done_q <= rcv_done_d;
         rd_req_q   <= rd_req_d;
      end
   end

endmodule
